// File: rtl/definitions.sv
// Shared opcode encoding for the sequencer core; the branch unit only acts on
// OP_CBF ('[') and OP_CBB (']').
package definitions;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_INC  = 4'd1,
    OP_DEC  = 4'd2,
    OP_PREV = 4'd3,
    OP_NEXT = 4'd4,
    OP_OUT  = 4'd5,
    OP_IN   = 4'd6,
    OP_CBF  = 4'd7,
    OP_CBB  = 4'd8
  } op_code;

endpackage

// File: rtl/loop_branch_unit.sv
// Conditional branch resolver: return-address stack for zero-cycle loop-back,
// bracket scanning with a nesting-depth counter when the target is not stacked.
//
// state      | meaning
// IDLE       | normal execution, branches resolved from data and stack
// SCAN_FWD   | skipping forward to the matching ']', instructions suppressed
// SCAN_BWD   | walking backward to the matching '[', instructions suppressed
// ERROR      | unmatched bracket seen, everything suppressed until reset
module loop_branch_unit
  import definitions::*;
#(
  parameter int PC_W        = 16,
  parameter int DATA_W      = 8,
  parameter int DEPTH_W     = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           instr_valid,
  input  op_code                         instruction,
  input  logic [PC_W-1:0]                pc,
  input  logic [DATA_W-1:0]              data,
  input  logic                           prog_end,
  output logic                           pc_load,
  output logic [PC_W-1:0]                pc_target,
  output logic                           fetch_dir,
  output logic                           suppress,
  output logic                           err_unmatched,
  output logic [$clog2(STACK_DEPTH):0]   stack_level
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN_FWD, S_SCAN_BWD, S_ERROR} state_t;

  state_t               state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [DEPTH_W-1:0]   lost_q, lost_d;
  logic [SP_W-1:0]      sp_q, sp_d;
  logic                 fresh_q, fresh_d;
  logic [PC_W-1:0]      stack_q [STACK_DEPTH];
  logic [PC_W-1:0]      stack_d [STACK_DEPTH];

  logic                 is_cbf, is_cbb, data_zero;
  logic                 stack_full, stack_empty, lost_zero;
  logic                 depth_max, depth_one;
  logic                 push_req, push_en;
  logic [IDX_W-1:0]     top_idx;
  logic [PC_W-1:0]      top_pc, pc_inc, pc_dec;

  assign is_cbf      = instr_valid && (instruction == OP_CBF);
  assign is_cbb      = instr_valid && (instruction == OP_CBB);
  assign data_zero   = (data == '0);
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign lost_zero   = (lost_q == '0);
  assign depth_max   = &depth_q;
  assign depth_one   = (depth_q == DEPTH_W'(1));
  assign top_idx     = IDX_W'(sp_q - SP_W'(1));
  assign top_pc      = stack_q[top_idx];
  assign pc_inc      = pc + PC_W'(1);
  assign pc_dec      = pc - PC_W'(1);
  assign stack_level = sp_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      lost_q  <= '0;
      sp_q    <= '0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      lost_q  <= lost_d;
      sp_q    <= sp_d;
      fresh_q <= fresh_d;
    end
  end

  // Stack contents are only meaningful below sp, so they are never cleared.
  always_ff @(posedge clock) begin
    stack_q <= stack_d;
  end

  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    lost_d   = lost_q;
    sp_d     = sp_q;
    fresh_d  = fresh_q;
    push_req = 1'b0;
    push_en  = 1'b0;
    stack_d  = stack_q;
    case (state_q)
      S_IDLE: begin
        if (is_cbf) begin
          if (!data_zero) begin
            push_req = 1'b1;
          end else begin
            depth_d = DEPTH_W'(1);
            state_d = S_SCAN_FWD;
          end
        end else if (is_cbb) begin
          if (data_zero) begin
            if (lost_zero && !stack_empty) sp_d = sp_q - SP_W'(1);
            else if (!lost_zero)           lost_d = lost_q - DEPTH_W'(1);
            else                           state_d = S_ERROR;
          end else if (!(lost_zero && !stack_empty)) begin
            depth_d = DEPTH_W'(1);
            state_d = S_SCAN_BWD;
            fresh_d = stack_empty && lost_zero;
          end
        end
      end
      S_SCAN_FWD: begin
        if (instr_valid) begin
          if (prog_end) begin
            state_d = S_ERROR;
          end else if (is_cbf) begin
            if (depth_max) state_d = S_ERROR;
            else           depth_d = depth_q + DEPTH_W'(1);
          end else if (is_cbb) begin
            depth_d = depth_q - DEPTH_W'(1);
            if (depth_one) state_d = S_IDLE;
          end
        end
      end
      S_SCAN_BWD: begin
        if (instr_valid) begin
          if (prog_end) begin
            state_d = S_ERROR;
          end else if (is_cbb) begin
            if (depth_max) state_d = S_ERROR;
            else           depth_d = depth_q + DEPTH_W'(1);
          end else if (is_cbf) begin
            depth_d = depth_q - DEPTH_W'(1);
            if (depth_one) begin
              state_d  = S_IDLE;
              // A stale entry was already counted when the scan started.
              push_req = fresh_q;
            end
          end
        end
      end
      S_ERROR: ;
      default: state_d = S_ERROR;
    endcase

    if (push_req) begin
      if (stack_full) begin
        if (lost_q != '1) lost_d = lost_q + DEPTH_W'(1);
      end else begin
        push_en = 1'b1;
        sp_d    = sp_q + SP_W'(1);
      end
    end
    if (push_en) stack_d[sp_q[IDX_W-1:0]] = pc_inc;
  end

  always_comb begin
    pc_load       = 1'b0;
    pc_target     = '0;
    fetch_dir     = 1'b0;
    suppress      = 1'b0;
    err_unmatched = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_cbb && !data_zero) begin
          pc_load   = 1'b1;
          pc_target = (lost_zero && !stack_empty) ? top_pc : pc_dec;
        end
      end
      S_SCAN_FWD: begin
        suppress = instr_valid;
      end
      S_SCAN_BWD: begin
        fetch_dir = 1'b1;
        suppress  = instr_valid;
        if (is_cbf && depth_one && !prog_end) begin
          pc_load   = 1'b1;
          pc_target = pc_inc;
          fetch_dir = 1'b0;
        end
      end
      S_ERROR: begin
        suppress      = 1'b1;
        err_unmatched = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_loop_branch_unit.sv
// Directed-vector bench for loop_branch_unit (two-entry stack so overflow is
// reachable), plus hand sequences for depth overflow and backward run-off.
module tb_loop_branch_unit;
  import definitions::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         instr_valid;
  op_code       instruction;
  logic [15:0]  pc;
  logic [7:0]   data;
  logic         prog_end;
  logic         pc_load;
  logic [15:0]  pc_target;
  logic         fetch_dir;
  logic         suppress;
  logic         err_unmatched;
  logic [1:0]   stack_level;

  int n_tests = 0;
  int n_fail  = 0;

  loop_branch_unit #(
    .PC_W(16), .DATA_W(8), .DEPTH_W(8), .STACK_DEPTH(2)
  ) u_dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid),
    .instruction(instruction), .pc(pc), .data(data), .prog_end(prog_end),
    .pc_load(pc_load), .pc_target(pc_target), .fetch_dir(fetch_dir),
    .suppress(suppress), .err_unmatched(err_unmatched),
    .stack_level(stack_level)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        vld;
    op_code      op;
    logic [15:0] pc;
    logic [7:0]  dat;
    logic        pend;
    logic        ld;
    logic [15:0] tgt;
    logic        dir;
    logic        sup;
    logic        err;
    logic [1:0]  lvl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic vld, input op_code op,
                     input int p, input int d, input logic pend,
                     input logic ld, input int tgt, input logic dir,
                     input logic sup, input logic err, input int lvl);
    vec_t v;
    v.rst = rst; v.vld = vld; v.op = op; v.pc = 16'(p); v.dat = 8'(d);
    v.pend = pend; v.ld = ld; v.tgt = 16'(tgt); v.dir = dir; v.sup = sup;
    v.err = err; v.lvl = 2'(lvl);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic vld, input op_code op,
                       input int p, input int d, input logic pend);
    reset = rst; instr_valid = vld; instruction = op;
    pc = 16'(p); data = 8'(d); prog_end = pend;
  endtask

  task automatic check(input string name, input logic ld, input logic [15:0] tgt,
                       input logic dir, input logic sup, input logic err,
                       input logic [1:0] lvl);
    n_tests++;
    if ({pc_load, pc_target, fetch_dir, suppress, err_unmatched, stack_level} !==
        {ld, tgt, dir, sup, err, lvl}) begin
      n_fail++;
      $display("FAIL %s: got ld=%b tgt=%0d dir=%b sup=%b err=%b lvl=%0d, want ld=%b tgt=%0d dir=%b sup=%b err=%b lvl=%0d",
               name, pc_load, pc_target, fetch_dir, suppress, err_unmatched, stack_level,
               ld, tgt, dir, sup, err, lvl);
    end
  endtask

  initial begin
    // Expected columns are the outputs seen before the edge that consumes the row.
    //   rst vld op      pc  dat pend  ld tgt dir sup err lvl
    add(0, 0, OP_NOP,   0,  0, 0,    0, 0,  0,  0,  0,  0);   // reset state
    // loop taken
    add(0, 1, OP_CBF,   4,  3, 0,    0, 0,  0,  0,  0,  0);
    add(0, 1, OP_NOP,   5,  3, 0,    0, 0,  0,  0,  0,  1);
    add(0, 1, OP_CBB,   9,  2, 0,    1, 5,  0,  0,  0,  1);
    add(0, 1, OP_CBB,   9,  0, 0,    0, 0,  0,  0,  0,  1);
    add(0, 1, OP_NOP,  10,  0, 0,    0, 0,  0,  0,  0,  0);
    // forward skip with nesting, including an invalid cycle mid-scan
    add(0, 1, OP_CBF,   0,  0, 0,    0, 0,  0,  0,  0,  0);
    add(0, 1, OP_CBF,   1,  0, 0,    0, 0,  0,  1,  0,  0);
    add(0, 0, OP_CBB,   2,  0, 0,    0, 0,  0,  0,  0,  0);
    add(0, 1, OP_INC,   2,  0, 0,    0, 0,  0,  1,  0,  0);
    add(0, 1, OP_CBB,   3,  0, 0,    0, 0,  0,  1,  0,  0);
    add(0, 1, OP_CBB,   4,  0, 0,    0, 0,  0,  1,  0,  0);
    add(0, 1, OP_INC,   5,  0, 0,    0, 0,  0,  0,  0,  0);
    // overflow fallback: third push lost, inner ']' scans back
    add(0, 1, OP_CBF,  10,  1, 0,    0, 0,  0,  0,  0,  0);
    add(0, 1, OP_CBF,  11,  1, 0,    0, 0,  0,  0,  0,  1);
    add(0, 1, OP_CBF,  12,  1, 0,    0, 0,  0,  0,  0,  2);
    add(0, 1, OP_INC,  13,  1, 0,    0, 0,  0,  0,  0,  2);
    add(0, 1, OP_CBB,  14,  1, 0,    1, 13, 0,  0,  0,  2);
    add(0, 1, OP_INC,  13,  1, 0,    0, 0,  1,  1,  0,  2);
    add(0, 1, OP_CBF,  12,  1, 0,    1, 13, 0,  1,  0,  2);
    add(0, 1, OP_INC,  13,  1, 0,    0, 0,  0,  0,  0,  2);
    add(0, 1, OP_CBB,  14,  0, 0,    0, 0,  0,  0,  0,  2);   // consumes lost
    add(0, 1, OP_CBB,  15,  1, 0,    1, 12, 0,  0,  0,  2);
    add(0, 1, OP_CBB,  15,  0, 0,    0, 0,  0,  0,  0,  2);
    add(0, 1, OP_CBB,  16,  0, 0,    0, 0,  0,  0,  0,  1);
    add(0, 1, OP_NOP,  17,  0, 0,    0, 0,  0,  0,  0,  0);
    // backward scan from an empty stack pushes a fresh entry
    add(0, 1, OP_CBB,  20,  1, 0,    1, 19, 0,  0,  0,  0);
    add(0, 1, OP_CBB,  19,  0, 0,    0, 0,  1,  1,  0,  0);
    add(0, 1, OP_CBF,  18,  0, 0,    0, 0,  1,  1,  0,  0);
    add(0, 1, OP_CBF,  17,  0, 0,    1, 18, 0,  1,  0,  0);
    add(0, 1, OP_NOP,  18,  0, 0,    0, 0,  0,  0,  0,  1);
    add(0, 1, OP_CBB,  20,  1, 0,    1, 18, 0,  0,  0,  1);
    add(0, 1, OP_CBB,  20,  0, 0,    0, 0,  0,  0,  0,  1);
    add(0, 1, OP_NOP,  21,  0, 0,    0, 0,  0,  0,  0,  0);
    // unmatched: scan runs off the program
    add(0, 1, OP_CBF,   0,  0, 0,    0, 0,  0,  0,  0,  0);
    add(0, 1, OP_INC,   1,  0, 0,    0, 0,  0,  1,  0,  0);
    add(0, 1, OP_INC,   2,  0, 1,    0, 0,  0,  1,  0,  0);
    add(0, 1, OP_NOP,   3,  0, 0,    0, 0,  0,  1,  1,  0);
    add(0, 1, OP_CBB,   4,  1, 0,    0, 0,  0,  1,  1,  0);
    add(1, 1, OP_NOP,   5,  0, 0,    0, 0,  0,  1,  1,  0);
    add(0, 0, OP_NOP,   0,  0, 0,    0, 0,  0,  0,  0,  0);
    // empty-stack ']' with zero data
    add(0, 1, OP_CBB,   3,  0, 0,    0, 0,  0,  0,  0,  0);
    add(0, 1, OP_NOP,   4,  0, 0,    0, 0,  0,  1,  1,  0);
    add(1, 1, OP_NOP,   5,  0, 0,    0, 0,  0,  1,  1,  0);
    add(0, 0, OP_NOP,   0,  0, 0,    0, 0,  0,  0,  0,  0);
    // reset mid forward scan at depth 3 clears the stack
    add(0, 1, OP_CBF,   0,  5, 0,    0, 0,  0,  0,  0,  0);
    add(0, 1, OP_CBF,   1,  0, 0,    0, 0,  0,  0,  0,  1);
    add(0, 1, OP_CBF,   2,  0, 0,    0, 0,  0,  1,  0,  1);
    add(0, 1, OP_CBF,   3,  0, 0,    0, 0,  0,  1,  0,  1);
    add(1, 1, OP_INC,   4,  0, 0,    0, 0,  0,  1,  0,  1);
    add(0, 0, OP_NOP,   0,  0, 0,    0, 0,  0,  0,  0,  0);
    add(0, 1, OP_CBF,   7,  1, 0,    0, 0,  0,  0,  0,  0);
    add(0, 1, OP_CBB,   9,  1, 0,    1, 8,  0,  0,  0,  1);
    add(0, 1, OP_CBB,   9,  0, 0,    0, 0,  0,  0,  0,  1);
    add(0, 1, OP_NOP,  10,  0, 0,    0, 0,  0,  0,  0,  0);

    drive(1, 0, OP_NOP, 0, 0, 0);
    repeat (2) @(posedge clock);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].rst, vecs[i].vld, vecs[i].op, int'(vecs[i].pc),
            int'(vecs[i].dat), vecs[i].pend);
      #1;
      check($sformatf("vec%0d", i), vecs[i].ld, vecs[i].tgt, vecs[i].dir,
            vecs[i].sup, vecs[i].err, vecs[i].lvl);
    end

    // depth counter overflow: 255 is the last legal depth
    @(negedge clock); drive(0, 1, OP_CBF, 0, 0, 0);
    for (int k = 0; k < 254; k++) begin
      @(negedge clock); drive(0, 1, OP_CBF, k + 1, 0, 0);
    end
    @(negedge clock); drive(0, 1, OP_CBF, 300, 0, 0); #1;
    check("depth_at_max", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 2'd0);
    @(negedge clock); drive(0, 1, OP_NOP, 301, 0, 0); #1;
    check("depth_overflow_err", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 2'd0);
    @(negedge clock); drive(1, 0, OP_NOP, 0, 0, 0);
    @(negedge clock); drive(0, 0, OP_NOP, 0, 0, 0); #1;
    check("reset_after_overflow", 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 2'd0);

    // backward scan running off the start of the program
    @(negedge clock); drive(0, 1, OP_CBB, 50, 1, 0); #1;
    check("bwd_enter", 1'b1, 16'd49, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clock); drive(0, 1, OP_INC, 49, 1, 1); #1;
    check("bwd_prog_end", 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 2'd0);
    @(negedge clock); drive(0, 1, OP_NOP, 48, 1, 0); #1;
    check("bwd_err", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
